// File: rtl/turf_bus_master_arb_pkg.sv
// Shared TURF bus constants: FSM state encoding, bytes per word, address bank map
// and the legal ranges of the master's timing parameters.
package turf_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_RWAIT = 3'd3,
        ST_RDATA = 3'd4,
        ST_GAP   = 3'd5
    } state_e;

    localparam int NUM_BYTES = 4;

    // Address [7:6] selects the bank, [5:0] the index within it.
    localparam logic [1:0] BANK_REGS = 2'd0;
    localparam logic [1:0] BANK_EVT0 = 2'd1;
    localparam logic [1:0] BANK_EVT1 = 2'd2;
    localparam logic [1:0] BANK_SCAL = 2'd3;

    localparam int RD_DLY_MIN = 1;
    localparam int RD_DLY_MAX = 7;
    localparam int GAP_MIN    = 1;
    localparam int GAP_MAX    = 3;

endpackage

// File: rtl/turf_bus_master_arb_if.sv
// TURF byte-wide bus as seen by the master (drives nCS/WnR/DIO) and the slave.
interface turf_bus_master_arb_if;
    logic       bus_ncs_o;
    logic       bus_wnr_o;
    logic [7:0] bus_do_o;
    logic       bus_oe_o;
    logic [7:0] bus_di_i;

    modport master (output bus_ncs_o, bus_wnr_o, bus_do_o, bus_oe_o, input bus_di_i);
    modport slave  (input bus_ncs_o, bus_wnr_o, bus_do_o, bus_oe_o, output bus_di_i);
endinterface

// File: rtl/turf_rr_arb2.sv
// Two-way arbiter with one-hot grant. Round-robin by default; strict priority to
// request 0 when TURF_BUS_FIXED_PRIO_EN is defined.
module turf_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);
`ifdef TURF_BUS_FIXED_PRIO_EN
    always_comb begin
        gnt_o = 2'b00;
        if (req_i[0])      gnt_o = 2'b01;
        else if (req_i[1]) gnt_o = 2'b10;
    end
`else
    // last_q = 1 means requester 1 won most recently, so a tie goes to 0.
    logic last_q, last_d;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (accept_i && (gnt_o != 2'b00)) last_d = gnt_o[1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) last_q <= 1'b1;
        else       last_q <= last_d;
    end
`endif
endmodule

// File: rtl/turf_bus_master_arb.sv
// Arbitrates two requesters onto the TURF byte bus: address cycle, four data bytes
// LSB first, then a bus-release gap. Optional macro: TURF_BUS_FIXED_PRIO_EN.
module turf_bus_master_arb
    import turf_bus_pkg::*;
#(
    parameter int RD_SAMPLE_DLY = 2,
    parameter int GAP_CYCLES    = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    input  logic        req0_wr_i,
    input  logic [7:0]  req0_addr_i,
    input  logic [31:0] req0_wdata_i,
    output logic        req0_ready_o,
    output logic        req0_done_o,
    output logic [31:0] req0_rdata_o,
    input  logic        req1_valid_i,
    input  logic        req1_wr_i,
    input  logic [7:0]  req1_addr_i,
    input  logic [31:0] req1_wdata_i,
    output logic        req1_ready_o,
    output logic        req1_done_o,
    output logic [31:0] req1_rdata_o,
    turf_bus_master_arb_if.master bus
);
    if (RD_SAMPLE_DLY < RD_DLY_MIN || RD_SAMPLE_DLY > RD_DLY_MAX) begin : g_bad_dly
        $error("RD_SAMPLE_DLY out of range");
    end
    if (GAP_CYCLES < GAP_MIN || GAP_CYCLES > GAP_MAX) begin : g_bad_gap
        $error("GAP_CYCLES out of range");
    end

    localparam logic [2:0] LAST_BYTE  = 3'(NUM_BYTES - 1);
    localparam logic [2:0] RWAIT_LAST = 3'(RD_SAMPLE_DLY - 2);
    localparam logic [2:0] GAP_LAST   = 3'(GAP_CYCLES - 1);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [7:0]        addr_q, addr_d;
    logic [31:0]       shreg_q, shreg_d;
    logic              gsel_q, gsel_d;
    logic [1:0][31:0]  rdata_q, rdata_d;

    logic [1:0] req_vld, gnt;
    logic       accept, done;
    logic       ncs, wnr, oe;
    logic [7:0] dout;

    assign req_vld = {req1_valid_i, req0_valid_i};
    assign accept  = (state_q == ST_IDLE) && (req_vld != 2'b00) && !rst_i;

    turf_rr_arb2 u_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_vld),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    // shreg_q shifts write bytes out of [7:0] and read bytes in at [31:24].
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        shreg_d = shreg_q;
        gsel_d  = gsel_q;
        rdata_d = rdata_q;
        ncs     = 1'b1;
        wnr     = wr_q;
        oe      = 1'b0;
        dout    = 8'h00;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wnr = 1'b1;
                if (accept) begin
                    gsel_d  = gnt[1];
                    wr_d    = gnt[1] ? req1_wr_i    : req0_wr_i;
                    addr_d  = gnt[1] ? req1_addr_i  : req0_addr_i;
                    shreg_d = gnt[1] ? req1_wdata_i : req0_wdata_i;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                ncs   = 1'b0;
                oe    = 1'b1;
                dout  = addr_q;
                cnt_d = 3'd0;
                if (wr_q)                    state_d = ST_WDATA;
                else if (RD_SAMPLE_DLY == 1) state_d = ST_RDATA;
                else                         state_d = ST_RWAIT;
            end
            ST_WDATA: begin
                oe      = 1'b1;
                dout    = shreg_q[7:0];
                shreg_d = {8'h00, shreg_q[31:8]};
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == LAST_BYTE) begin
                    cnt_d   = 3'd0;
                    state_d = ST_GAP;
                end
            end
            ST_RWAIT: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == RWAIT_LAST) begin
                    cnt_d   = 3'd0;
                    state_d = ST_RDATA;
                end
            end
            ST_RDATA: begin
                shreg_d = {bus.bus_di_i, shreg_q[31:8]};
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == LAST_BYTE) begin
                    rdata_d[gsel_q] = shreg_d;
                    cnt_d           = 3'd0;
                    state_d         = ST_GAP;
                end
            end
            ST_GAP: begin
                done  = (cnt_q == 3'd0);
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 3'd0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            wr_q    <= 1'b1;
            addr_q  <= 8'h00;
            shreg_q <= 32'h0;
            gsel_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            shreg_q <= shreg_d;
            gsel_q  <= gsel_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.bus_ncs_o = ncs;
    assign bus.bus_wnr_o = wnr;
    assign bus.bus_oe_o  = oe;
    assign bus.bus_do_o  = dout;

    assign req0_ready_o = accept & gnt[0];
    assign req1_ready_o = accept & gnt[1];
    assign req0_done_o  = done & !gsel_q & !rst_i;
    assign req1_done_o  = done &  gsel_q & !rst_i;
    assign req0_rdata_o = rdata_q[0];
    assign req1_rdata_o = rdata_q[1];

endmodule

// File: tb/tb_turf_bus_master_arb.sv
// Scoreboard bench: accepts are predicted by a transaction-level model that queues
// expected bus cycles and completions; a monitor pops and compares each cycle.
module tb_turf_bus_master_arb;
    localparam int D = 2;
    localparam int G = 1;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]       vld, wr, rdy, dn;
    logic [1:0][7:0]  addr;
    logic [1:0][31:0] wdata, rdata;
    logic [7:0]       di_tab [256];

    turf_bus_master_arb_if bus ();
    assign bus.bus_di_i = di_tab[cyc[7:0]];

    turf_bus_master_arb u_dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(vld[0]), .req0_wr_i(wr[0]), .req0_addr_i(addr[0]), .req0_wdata_i(wdata[0]),
        .req0_ready_o(rdy[0]), .req0_done_o(dn[0]), .req0_rdata_o(rdata[0]),
        .req1_valid_i(vld[1]), .req1_wr_i(wr[1]), .req1_addr_i(addr[1]), .req1_wdata_i(wdata[1]),
        .req1_ready_o(rdy[1]), .req1_done_o(dn[1]), .req1_rdata_o(rdata[1]),
        .bus(bus)
    );

    // Second instance: short read timing with a long gap.
    logic        v2, rdy2, dn2, rdy2b, dn2b;
    logic [31:0] rd2, rd2b;
    logic [7:0]  di2;
    turf_bus_master_arb_if bus2 ();
    assign bus2.bus_di_i = di2;

    turf_bus_master_arb #(.RD_SAMPLE_DLY(1), .GAP_CYCLES(3)) u_dut2 (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(v2), .req0_wr_i(1'b0), .req0_addr_i(8'h83), .req0_wdata_i(32'h0),
        .req0_ready_o(rdy2), .req0_done_o(dn2), .req0_rdata_o(rd2),
        .req1_valid_i(1'b0), .req1_wr_i(1'b0), .req1_addr_i(8'h00), .req1_wdata_i(32'h0),
        .req1_ready_o(rdy2b), .req1_done_o(dn2b), .req1_rdata_o(rd2b),
        .bus(bus2)
    );

    typedef struct { int cyc; logic ncs; logic oe; logic wnr; logic [7:0] d; logic cd; } bus_e;
    typedef struct { int id; int cyc; logic [31:0] rdata; } done_e;

    bus_e        bq[$];
    done_e       dq[$];
    logic [31:0] mrd [2];
    int          last_g, next_ok;
    int          n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    endtask

    // Model of one accepted transaction: every non-idle bus cycle plus its completion.
    task automatic push(input int g, input int a);
        int          dcyc;
        logic [31:0] exp;
        bq.push_back('{a + 1, 1'b0, 1'b1, wr[g], addr[g], 1'b1});
        if (wr[g]) begin
            for (int k = 0; k < 4; k++) bq.push_back('{a + 2 + k, 1'b1, 1'b1, 1'b1, wdata[g][8*k +: 8], 1'b1});
            dcyc = a + 6;
            exp  = mrd[g];
        end else begin
            for (int c = a + 2; c <= a + D + 4; c++) bq.push_back('{c, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
            dcyc = a + D + 5;
            for (int k = 0; k < 4; k++) exp[8*k +: 8] = di_tab[(a + 1 + D + k) % 256];
        end
        for (int j = 0; j < G; j++) bq.push_back('{dcyc + j, 1'b1, 1'b0, wr[g], 8'h00, 1'b0});
        dq.push_back('{g, dcyc, exp});
        mrd[g]  = exp;
        next_ok = dcyc + G;
        last_g  = g;
    endtask

    task automatic monitor();
        bus_e        e;
        done_e       d;
        logic [1:0]  egnt, edn;
        int          g;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_ready", 32'(rdy), 32'h0);
                chk("rst_done", 32'(dn), 32'h0);
                bq.delete();
                dq.delete();
                last_g  = 1;
                next_ok = cyc + 1;
                mrd[0]  = 32'h0;
                mrd[1]  = 32'h0;
            end else begin
                if (bq.size() > 0 && bq[0].cyc == cyc) begin
                    e = bq.pop_front();
                    chk("bus_cycle", {bus.bus_ncs_o, bus.bus_oe_o, bus.bus_wnr_o, (e.cd ? bus.bus_do_o : 8'h00)},
                        {e.ncs, e.oe, e.wnr, e.d});
                end else begin
                    chk("bus_idle", {bus.bus_ncs_o, bus.bus_oe_o, bus.bus_wnr_o, bus.bus_do_o}, {3'b101, 8'h00});
                end
                egnt = 2'b00;
                g    = 0;
                if (cyc >= next_ok && vld != 2'b00) begin
`ifdef TURF_BUS_FIXED_PRIO_EN
                    g = vld[0] ? 0 : 1;
`else
                    g = (vld == 2'b11) ? ((last_g == 1) ? 0 : 1) : (vld[0] ? 0 : 1);
`endif
                    egnt[g] = 1'b1;
                end
                chk("ready", 32'(rdy), 32'(egnt));
                if (egnt != 2'b00) push(g, cyc);
                edn = 2'b00;
                if (dq.size() > 0 && dq[0].cyc == cyc) begin
                    d = dq.pop_front();
                    edn[d.id] = 1'b1;
                    chk("rdata", rdata[d.id], d.rdata);
                    chk("rdata_other", rdata[1 - d.id], mrd[1 - d.id]);
                end
                chk("done", 32'(dn), 32'(edn));
            end
        end
    endtask

    task automatic do_req(input int i, input logic w, input logic [7:0] a, input logic [31:0] wd);
        int n;
        @(posedge clk); #1;
        wr[i] = w; addr[i] = a; wdata[i] = wd; vld[i] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!rdy[i] && n < 50);
        if (!rdy[i]) chk("ready_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
        vld[i] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!dn[i] && n < 30);
        if (!dn[i]) chk("done_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        logic [1:0] seen;
        int         idle [2];
        int         pat [2];
        int         n;
        for (int i = 0; i < 256; i++) di_tab[i] = 8'($urandom);
        rst = 1'b1; vld = '0; wr = '0; addr = '0; wdata = '0; v2 = 1'b0; di2 = 8'h00;
        last_g = 1; next_ok = 0; mrd[0] = 32'h0; mrd[1] = 32'h0;
        fork monitor(); join_none
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("reset_rdata0", rdata[0], 32'h0);
        chk("reset_rdata1", rdata[1], 32'h0);
        chk("reset_bus2", {bus2.bus_ncs_o, bus2.bus_oe_o, bus2.bus_wnr_o, bus2.bus_do_o}, {3'b101, 8'h00});

        // Short-delay instance: continuous read valid, bytes on cycles 1..4 after ADDR.
        @(posedge clk); #1 v2 = 1'b1;
        @(negedge clk);
        chk("d1_ready_first", 32'(rdy2), 32'h1);
        for (int r = 0; r <= 10; r++) begin
            @(posedge clk); #1 di2 = 8'(8'h10 + r);
            @(negedge clk);
            chk("d1_ncs_oe", {bus2.bus_ncs_o, bus2.bus_oe_o}, (r == 0 || r == 9) ? 2'b01 : 2'b10);
            chk("d1_done", 32'(dn2), (r == 5) ? 32'h1 : 32'h0);
            chk("d1_ready", 32'(rdy2), (r == 8) ? 32'h1 : 32'h0);
            if (r == 5) chk("d1_rdata", rd2, 32'h14131211);
        end
        v2 = 1'b0;

        do_req(0, 1'b1, 8'h04, 32'hDEADBEEF);
        do_req(1, 1'b0, 8'hC5, 32'h0);
        do_req(0, 1'b0, 8'h41, 32'h0);
        do_req(1, 1'b1, 8'h80, 32'h12345678);

        // Both requesters held valid: grants must follow the arbitration rule.
        @(posedge clk); #1;
        wr = 2'b10; addr[0] = 8'h11; addr[1] = 8'h22; wdata[1] = 32'hCAFEF00D; vld = 2'b11;
        repeat (40) @(posedge clk);
        #1 vld = 2'b00;
        repeat (20) @(negedge clk);

        // Reset while the third write byte is on the bus.
        @(posedge clk); #1;
        wr[0] = 1'b1; addr[0] = 8'h10; wdata[0] = 32'h01020304; vld[0] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!rdy[0] && n < 50);
        if (!rdy[0]) chk("rst_test_ready_timeout", 32'h0, 32'h1);
        @(posedge clk); #1 vld[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_bus", {bus.bus_ncs_o, bus.bus_oe_o}, 2'b10);
        chk("post_rst_done", 32'(dn), 32'h0);
        do_req(0, 1'b1, 8'h3F, 32'hA5A55A5A);

        // Random traffic with occasional withdrawals and one reset.
        idle[0] = 0; idle[1] = 3; pat[0] = 0; pat[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            seen = rdy;
            @(posedge clk); #1;
            rst = (c == 1500);
            for (int i = 0; i < 2; i++) begin
                if (vld[i]) begin
                    if (seen[i]) begin
                        vld[i]  = 1'b0;
                        idle[i] = $urandom_range(0, 6);
                    end else if (pat[i] == 0) vld[i] = 1'b0;
                    else pat[i]--;
                end else if (idle[i] != 0) idle[i]--;
                else begin
                    vld[i]   = 1'b1;
                    wr[i]    = 1'($urandom);
                    addr[i]  = 8'($urandom);
                    wdata[i] = $urandom;
                    pat[i]   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 100;
                end
            end
        end
        rst = 1'b0;
        vld = 2'b00;
        repeat (30) @(negedge clk);
        chk("drain", 32'(bq.size() + dq.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/turf_bus_master_arb.md
TURF_BUS_MASTER_ARB -- requirements
Module: turf_bus_master_arb

Interface
REQ-001 SHALL have parameter RD_SAMPLE_DLY, default 2, cycles from address cycle to first read-byte sample (legal 1..7).
REQ-002 SHALL have parameter GAP_CYCLES, default 1, idle cycles after each transaction with nCS high and bus released (legal 1..3).
REQ-003 SHALL have clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have reqN_valid_i (N=0,1)  input  1  requester N has a pending transaction.
REQ-006 SHALL have reqN_wr_i  input  1  1=write, 0=read.
REQ-007 SHALL have reqN_addr_i  input  8  bus address; [7:6] bank (0 regs, 1/2 event, 3 scalers), [5:0] index.
REQ-008 SHALL have reqN_wdata_i  input  32  write data.
REQ-009 SHALL have reqN_ready_o  output  1  one-cycle accept pulse; request fields sampled on this cycle.
REQ-010 SHALL have reqN_done_o  output  1  one-cycle completion pulse.
REQ-011 SHALL have reqN_rdata_o  output  32  read data, valid from done until N's next done.
REQ-012 SHALL have bus_ncs_o  output  1  active-low chip select to TURF.
REQ-013 SHALL have bus_wnr_o  output  1  1=write, 0=read.
REQ-014 SHALL have bus_do_o / bus_oe_o  output  8 / 1  byte driven onto TURF_DIO and its enable.
REQ-015 SHALL have bus_di_i  input  8  byte sampled from TURF_DIO.

Function
REQ-016 States SHALL be IDLE, ADDR, WDATA, RWAIT, RDATA, GAP.
REQ-017 IDLE: if any valid, SHALL grant one requester, pulse its ready, latch wr/addr/wdata, go ADDR next cycle.
REQ-018 ADDR (1 cycle): ncs=0, wnr=latched wr, do=addr, oe=1; next WDATA if write, else RWAIT (or RDATA if RD_SAMPLE_DLY=1).
REQ-019 WDATA (4 cycles): ncs=1, oe=1, do = wdata byte 0,1,2,3 (LSB first); then GAP.
REQ-020 Read: oe=0 from cycle after ADDR; with ADDR as cycle 0, byte k SHALL be sampled from bus_di_i at cycle RD_SAMPLE_DLY+k, k=0..3, byte 0 into rdata[7:0].
REQ-021 nCS SHALL be low only in ADDR; wnr SHALL hold its ADDR value until GAP ends, then return to 1.
REQ-022 GAP: ncs=1, oe=0 for GAP_CYCLES; done of granted requester and rdata update (read) SHALL occur in first GAP cycle; then IDLE.
REQ-023 Write latency accept->done SHALL be 6 cycles; read SHALL be RD_SAMPLE_DLY+5.
REQ-024 Arbitration SHALL be round-robin: on simultaneous valid, grant the requester not granted last; single valid granted immediately.
REQ-025 Valid deasserted before ready SHALL start no transaction; requests arriving outside IDLE SHALL wait.
REQ-026 Write rdata_o SHALL be unchanged; only granted requester's done/rdata SHALL change.

Reset
REQ-027 On rst_i: state IDLE, ncs=1, wnr=1, do=0, oe=0, ready=0, done=0, rdata=0, last-grant = requester 1 (first tie goes to 0).
REQ-028 Reset mid-transaction SHALL abandon it with no done pulse; bus idle on the cycle after rst_i sampled high.

Configuration
REQ-029 Macro TURF_BUS_FIXED_PRIO_EN defined: requester 0 SHALL have strict priority over 1.
REQ-030 Macro undefined: round-robin per REQ-024.

Structure
REQ-031 Shared package turf_bus_pkg SHALL hold state encodings, byte count (4), bank field constants, parameter legal ranges.
REQ-032 Arbitration SHALL be sub-module turf_rr_arb2 (2 requests, grant one-hot, last-grant update on accept, fixed-priority under macro).

Verification
REQ-033 Req0 write addr 0x04 data 0xDEADBEEF -> ncs low 1 cycle with do=0x04, wnr=1; then do=EF,BE,AD,DE; done0 6 cycles after ready0.
REQ-034 Req1 read addr 0xC5, slave returns 11,22,33,44 at cycles 2..5 -> rdata1=0x44332211, done1 7 cycles after ready1, oe=0 from cycle 1.
REQ-035 Both valid continuously, round-robin -> grants alternate 0,1,0,1; fixed-prio build -> only 0 granted while valid0 high.
REQ-036 rst_i asserted during WDATA byte 2 -> next cycle ncs=1, oe=0, no done; following request completes normally.
REQ-037 RD_SAMPLE_DLY=1, GAP_CYCLES=3 read -> samples at cycles 1..4, done at cycle 5, next ADDR no earlier than cycle 9.
